// File: rtl/zliczanie_seq_if.sv
// Operand/result handshake bundle for zliczanie_seq; carries o_parity only when ZLICZANIE_PARITY_EN is defined.
// master drives the operand and consumes the result, slave is the counting unit.
interface zliczanie_seq_if #(
    parameter int BITS = 8
);
    localparam int RW = $clog2(2*BITS+1);

    logic signed [BITS-1:0] i_argA;
    logic signed [BITS-1:0] i_argB;
    logic [1:0]             i_mode;
    logic                   i_valid;
    logic                   o_ready;
    logic [RW-1:0]          o_result;
    logic                   o_valid;
    logic                   i_ready;
    logic                   o_busy;
`ifdef ZLICZANIE_PARITY_EN
    logic                   o_parity;

    modport master (
        output i_argA, i_argB, i_mode, i_valid, i_ready,
        input  o_ready, o_result, o_valid, o_busy, o_parity
    );
    modport slave (
        input  i_argA, i_argB, i_mode, i_valid, i_ready,
        output o_ready, o_result, o_valid, o_busy, o_parity
    );
`else
    modport master (
        output i_argA, i_argB, i_mode, i_valid, i_ready,
        input  o_ready, o_result, o_valid, o_busy
    );
    modport slave (
        input  i_argA, i_argB, i_mode, i_valid, i_ready,
        output o_ready, o_result, o_valid, o_busy
    );
`endif
endinterface

// File: rtl/zliczanie_seq.sv
// Sequential ones/zeros/CLZ/CTZ counter over {A,B}, CHUNK bits per cycle; result valid LEN/CHUNK cycles after accept,
// held in DONE until i_ready, no accept outside IDLE. ZLICZANIE_PARITY_EN adds o_parity (XOR of all operand bits).
module zliczanie_seq #(
    parameter int BITS  = 8,
    parameter int CHUNK = 4
) (
    input  logic           i_clk,
    input  logic           i_rst,
    zliczanie_seq_if.slave bus
);
    localparam int LEN = 2*BITS;
    localparam int NCH = LEN/CHUNK;
    localparam int RW  = $clog2(2*BITS+1);
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    generate
        if (LEN % CHUNK != 0) begin : g_chunk_check
            $error("zliczanie_seq: 2*BITS must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t           state, state_nxt;
    logic [LEN-1:0]   opnd;
    logic [1:0]       mode;
    logic [RW-1:0]    acc;
    logic [CW-1:0]    cnt;
    logic             hit;
    logic [CHUNK-1:0] chunk_raw;
    logic [CHUNK-1:0] chunk;
    logic [RW-1:0]    pop;
    logic [RW-1:0]    lz;
    logic [RW-1:0]    add;
    logic             seen;
`ifdef ZLICZANIE_PARITY_EN
    logic             par;
    assign bus.o_parity = par;
`endif

    assign bus.o_result = acc;

    // CTZ chunks are bit-reversed so one leading-zero scan serves both CLZ and CTZ.
    always_comb begin
        chunk_raw = (mode == 2'b11) ? opnd[CHUNK-1:0] : opnd[LEN-1 -: CHUNK];
        chunk     = chunk_raw;
        if (mode == 2'b11) begin
            for (int i = 0; i < CHUNK; i++) chunk[i] = chunk_raw[CHUNK-1-i];
        end
        pop  = '0;
        lz   = '0;
        seen = 1'b0;
        for (int i = CHUNK-1; i >= 0; i--) begin
            pop = pop + RW'(chunk[i]);
            if (chunk[i]) seen = 1'b1;
            else if (!seen) lz = lz + RW'(1);
        end
        case (mode)
            2'b00:   add = pop;
            2'b01:   add = RW'(CHUNK) - pop;
            default: add = hit ? '0 : lz;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        bus.o_ready = 1'b0;
        bus.o_valid = 1'b0;
        bus.o_busy  = 1'b1;
        case (state)
            IDLE: begin
                bus.o_ready = 1'b1;
                bus.o_busy  = 1'b0;
                if (bus.i_valid) state_nxt = COUNT;
            end
            COUNT: begin
                if (cnt == CW'(NCH-1)) state_nxt = DONE;
            end
            DONE: begin
                bus.o_valid = 1'b1;
                if (bus.i_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            opnd <= '0;
            mode <= '0;
            acc  <= '0;
            cnt  <= '0;
            hit  <= 1'b0;
`ifdef ZLICZANIE_PARITY_EN
            par  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.i_valid) begin
                    opnd <= {bus.i_argA, bus.i_argB};
                    mode <= bus.i_mode;
                    acc  <= '0;
                    cnt  <= '0;
                    hit  <= 1'b0;
`ifdef ZLICZANIE_PARITY_EN
                    par  <= 1'b0;
`endif
                end
                COUNT: begin
                    acc  <= acc + add;
                    hit  <= hit | (pop != '0);
                    cnt  <= cnt + CW'(1);
                    opnd <= (mode == 2'b11) ? (opnd >> CHUNK) : (opnd << CHUNK);
`ifdef ZLICZANIE_PARITY_EN
                    par  <= par ^ (^chunk_raw);
`endif
                end
                default: ;
            endcase
        end
    end
endmodule
